// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mst_state_e;

   localparam logic [3:0] BE_BYTE    = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // Context captured at accept and replayed to write-back on ack.
   typedef struct packed {
      logic              is_load;
      logic [1:0]        lane;
      logic [1:0]        size;
      logic              is_unsigned;
      logic              reg_write;
      logic [REG_AW-1:0] write_reg;
      logic [XLEN-1:0]   alu_result;
   } mem_ctx_t;

   // Byte enables for an access of the given size at the given lane.
   function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         MEM_B:   be = BE_BYTE << lane;
         MEM_H:   be = lane[1] ? BE_HALF_HI : BE_HALF_LO;
         default: be = BE_WORD;
      endcase
      return be;
   endfunction

   // Replicate store data across every lane it may land in.
   function automatic logic [XLEN-1:0] calc_wdata(input logic [1:0] size, input logic [XLEN-1:0] data);
      logic [XLEN-1:0] wd;
      case (size)
         MEM_B:   wd = {4{data[7:0]}};
         MEM_H:   wd = {2{data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Extracts the addressed lane from a read word and sign/zero-extends it.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr,
   input  logic [1:0]      size,
   input  logic            is_unsigned,
   output logic [XLEN-1:0] data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select and extension.
   always_comb begin
      case (addr)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         MEM_B:   data_c = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         MEM_H:   data_c = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: data_c = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues dmem loads/stores and hands a result bundle to write-back.
module mem_access_stage
   import mem_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic              reg_write,
   input  logic [REG_AW-1:0] write_reg,
   input  logic [XLEN-1:0]   alu_result,
   input  logic [XLEN-1:0]   store_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_ack,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic              wb_mem_to_reg,
   output logic [REG_AW-1:0] wb_write_reg,
   output logic [XLEN-1:0]   wb_alu_result,
   output logic [XLEN-1:0]   wb_mem_data,
   output logic              misalign_err
);

   mst_state_e        state_q, state_d;
   mem_ctx_t          ctx_q, ctx_d;
   logic              dmem_req_d, dmem_we_d;
   logic [XLEN-1:0]   dmem_addr_d, dmem_wdata_d;
   logic [3:0]        dmem_be_d;
   logic              wb_valid_d, wb_reg_write_d, wb_mem_to_reg_d, misalign_err_d;
   logic [REG_AW-1:0] wb_write_reg_d;
   logic [XLEN-1:0]   wb_alu_result_d, wb_mem_data_d;
   logic              is_mem, bad_access;
   logic [XLEN-1:0]   load_val_c;

   assign in_ready = (state_q == IDLE);

   load_align u_load_align (
      .rdata       (dmem_rdata),
      .addr        (ctx_q.lane),
      .size        (ctx_q.size),
      .is_unsigned (ctx_q.is_unsigned),
      .data_c      (load_val_c)
   );

   // Classify the incoming instruction; illegal accesses never reach memory.
   always_comb begin
      is_mem     = mem_read | mem_write;
      bad_access = 1'b0;
      if (is_mem) begin
         if (mem_read && mem_write) bad_access = 1'b1;
         case (mem_size)
            MEM_B:   ;
            MEM_H:   if (alu_result[0]) bad_access = 1'b1;
            MEM_W:   if (alu_result[1:0] != 2'b00) bad_access = 1'b1;
            default: bad_access = 1'b1;
         endcase
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d         = state_q;
      ctx_d           = ctx_q;
      dmem_req_d      = dmem_req;
      dmem_we_d       = dmem_we;
      dmem_addr_d     = dmem_addr;
      dmem_be_d       = dmem_be;
      dmem_wdata_d    = dmem_wdata;
      wb_valid_d      = 1'b0;
      misalign_err_d  = 1'b0;
      wb_reg_write_d  = wb_reg_write;
      wb_mem_to_reg_d = wb_mem_to_reg;
      wb_write_reg_d  = wb_write_reg;
      wb_alu_result_d = wb_alu_result;
      wb_mem_data_d   = wb_mem_data;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!is_mem || bad_access) begin
                  wb_valid_d      = 1'b1;
                  misalign_err_d  = is_mem;
                  wb_reg_write_d  = is_mem ? 1'b0 : reg_write;
                  wb_mem_to_reg_d = 1'b0;
                  wb_write_reg_d  = write_reg;
                  wb_alu_result_d = alu_result;
                  wb_mem_data_d   = '0;
               end else begin
                  state_d           = WAIT;
                  dmem_req_d        = 1'b1;
                  dmem_we_d         = mem_write;
                  dmem_addr_d       = {alu_result[XLEN-1:2], 2'b00};
                  dmem_be_d         = calc_be(mem_size, alu_result[1:0]);
                  dmem_wdata_d      = calc_wdata(mem_size, store_data);
                  ctx_d.is_load     = mem_read;
                  ctx_d.lane        = alu_result[1:0];
                  ctx_d.size        = mem_size;
                  ctx_d.is_unsigned = mem_unsigned;
                  ctx_d.reg_write   = reg_write;
                  ctx_d.write_reg   = write_reg;
                  ctx_d.alu_result  = alu_result;
               end
            end
         end
         WAIT: begin
            if (dmem_ack) begin
               state_d         = IDLE;
               dmem_req_d      = 1'b0;
               wb_valid_d      = 1'b1;
               wb_reg_write_d  = ctx_q.is_load & ctx_q.reg_write;
               wb_mem_to_reg_d = ctx_q.is_load;
               wb_write_reg_d  = ctx_q.write_reg;
               wb_alu_result_d = ctx_q.alu_result;
               wb_mem_data_d   = ctx_q.is_load ? load_val_c : '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Output and captured-context registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctx_q         <= '0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_be       <= '0;
         dmem_wdata    <= '0;
         wb_valid      <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_mem_to_reg <= 1'b0;
         wb_write_reg  <= '0;
         wb_alu_result <= '0;
         wb_mem_data   <= '0;
         misalign_err  <= 1'b0;
      end else begin
         ctx_q         <= ctx_d;
         dmem_req      <= dmem_req_d;
         dmem_we       <= dmem_we_d;
         dmem_addr     <= dmem_addr_d;
         dmem_be       <= dmem_be_d;
         dmem_wdata    <= dmem_wdata_d;
         wb_valid      <= wb_valid_d;
         wb_reg_write  <= wb_reg_write_d;
         wb_mem_to_reg <= wb_mem_to_reg_d;
         wb_write_reg  <= wb_write_reg_d;
         wb_alu_result <= wb_alu_result_d;
         wb_mem_data   <= wb_mem_data_d;
         misalign_err  <= misalign_err_d;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases, randomized traffic, reset abort.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic        mem_read, mem_write, mem_unsigned, reg_write;
   logic [1:0]  mem_size;
   logic [4:0]  write_reg;
   logic [31:0] alu_result, store_data;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_reg_write, wb_mem_to_reg, misalign_err;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_alu_result, wb_mem_data;

   mem_access_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
      .mem_unsigned(mem_unsigned), .reg_write(reg_write), .write_reg(write_reg),
      .alu_result(alu_result), .store_data(store_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_write_reg(wb_write_reg), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;
   logic chk_en = 1'b0;

   typedef struct {
      int          cyc;
      logic        rw, m2r, err;
      logic [4:0]  wreg;
      logic [31:0] alu, data;
   } wb_exp_t;

   typedef struct {
      int          s, e;
      logic        we;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
   } req_exp_t;

   wb_exp_t  wbq[$];
   req_exp_t rq[$];

   logic        last_m2r, last_rw, last_err;
   logic [4:0]  last_wreg;
   logic [31:0] last_alu, last_data, last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_we;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
      else n_pass++;
   endtask

   // Reference model: access size in bytes, legality, lanes, extension.
   function automatic int m_bytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic logic m_err(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
      if (!rd && !wr) return 1'b0;
      if (rd && wr) return 1'b1;
      if (sz == 2'd3) return 1'b1;
      return (a % m_bytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lane);
      int m;
      m = ((1 << m_bytes(sz)) - 1) << lane;
      return 4'(m);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
      if (sz == 2'd0) return sd[7:0] * 32'h0101_0101;
      if (sz == 2'd1) return sd[15:0] * 32'h0001_0001;
      return sd;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] sz, input logic uns);
      longint one = 1;
      longint v;
      int     bits;
      bits = 8 * m_bytes(sz);
      v = (longint'(w) >> (8 * lane)) & ((one << bits) - 1);
      if (!uns && bits < 32 && v >= (one << (bits - 1))) v = v - (one << bits);
      return 32'(v);
   endfunction

   // Compare process: every cycle, DUT outputs vs the model's expectation queues.
   always @(negedge clk) begin : cmp
      logic exp_v, exp_r;
      if (chk_en) begin
         exp_v = (wbq.size() > 0) && (wbq[0].cyc == cyc);
         chk("wb_valid", wb_valid, exp_v);
         chk("misalign_err", misalign_err, exp_v && wbq[0].err);
         if (wb_valid) begin
            last_m2r = wb_mem_to_reg; last_rw = wb_reg_write; last_err = misalign_err;
            last_wreg = wb_write_reg; last_alu = wb_alu_result; last_data = wb_mem_data;
         end
         if (exp_v) begin
            chk("wb_reg_write", wb_reg_write, wbq[0].rw);
            if (!wbq[0].err) begin
               chk("wb_mem_to_reg", wb_mem_to_reg, wbq[0].m2r);
               chk("wb_write_reg", wb_write_reg, wbq[0].wreg);
               chk("wb_alu_result", wb_alu_result, wbq[0].alu);
               chk("wb_mem_data", wb_mem_data, wbq[0].data);
            end
            void'(wbq.pop_front());
         end
         exp_r = (rq.size() > 0) && (cyc >= rq[0].s) && (cyc <= rq[0].e);
         chk("dmem_req", dmem_req, exp_r);
         chk("in_ready", in_ready, !exp_r);
         if (dmem_req) begin
            last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata; last_we = dmem_we;
         end
         if (exp_r) begin
            chk("dmem_we", dmem_we, rq[0].we);
            chk("dmem_addr", dmem_addr, rq[0].addr);
            chk("dmem_be", dmem_be, rq[0].be);
            chk("dmem_wdata", dmem_wdata, rq[0].wdata);
            if (cyc == rq[0].e) void'(rq.pop_front());
         end
      end
   end

   // Issue one instruction; memory ops get an ack after w wait cycles.
   task automatic do_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic rw, input logic [4:0] wreg, input logic [31:0] alu,
                         input logic [31:0] sd, input int w, input logic [31:0] rdata);
      int      cur;
      logic    err;
      wb_exp_t we_;
      req_exp_t re_;
      @(negedge clk);
      in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
      reg_write = rw; write_reg = wreg; alu_result = alu; store_data = sd;
      dmem_ack = 1'($urandom_range(0, 1));
      cur = cyc;
      err = m_err(rd, wr, sz, alu);
      we_.wreg = wreg; we_.alu = alu; we_.err = err;
      if (!(rd || wr) || err) begin
         we_.cyc = cur + 1; we_.rw = err ? 1'b0 : rw; we_.m2r = 1'b0; we_.data = '0;
         wbq.push_back(we_);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end else begin
         re_.s = cur + 1; re_.e = cur + 1 + w; re_.we = wr;
         re_.addr = {alu[31:2], 2'b00}; re_.be = m_be(sz, alu[1:0]); re_.wdata = m_wdata(sz, sd);
         rq.push_back(re_);
         we_.cyc = cur + 2 + w; we_.rw = rd & rw; we_.m2r = rd;
         we_.data = rd ? m_load(rdata, alu[1:0], sz, uns) : 32'd0;
         wbq.push_back(we_);
         for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            in_valid   = 1'($urandom_range(0, 1));
            alu_result = $urandom;
            dmem_ack   = (k == w);
            dmem_rdata = (k == w) ? rdata : $urandom;
         end
         @(negedge clk);
         in_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = $urandom;
      end
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0;
      mem_unsigned = 1'b0; reg_write = 1'b0; write_reg = '0; alu_result = '0; store_data = '0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_dmem_addr", dmem_addr, 0);
      chk("rst_dmem_be", dmem_be, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_alu", wb_alu_result, 0);
      chk("rst_wb_data", wb_mem_data, 0);
      chk("rst_misalign", misalign_err, 0);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Plan 1: plain ALU op.
      do_txn(0, 0, 2'd2, 0, 1, 5'd5, 32'h0000_1234, 32'h0, 0, 32'h0);
      settle();
      chk("t1_alu", last_alu, 32'h0000_1234);
      chk("t1_wreg", last_wreg, 5);
      chk("t1_m2r", last_m2r, 0);
      chk("t1_rw", last_rw, 1);
      // Plan 2: LB signed at 0x103, three wait cycles.
      do_txn(1, 0, 2'd0, 0, 1, 5'd7, 32'h0000_0103, 32'h0, 3, 32'h80FF_1122);
      settle();
      chk("t2_addr", last_addr, 32'h0000_0100);
      chk("t2_be", last_be, 4'b1000);
      chk("t2_data", last_data, 32'hFFFF_FF80);
      chk("t2_m2r", last_m2r, 1);
      // Plan 3: LHU at 0x002, immediate ack, then back-to-back ALU op.
      do_txn(1, 0, 2'd1, 1, 1, 5'd3, 32'h0000_0002, 32'h0, 0, 32'h8001_0000);
      settle();
      chk("t3_data", last_data, 32'h0000_8001);
      // Plan 4: SH at 0x202.
      do_txn(0, 1, 2'd1, 0, 1, 5'd9, 32'h0000_0202, 32'hABCD_1234, 1, 32'h0);
      settle();
      chk("t4_we", last_we, 1);
      chk("t4_be", last_be, 4'b1100);
      chk("t4_wdata", last_wdata, 32'h1234_1234);
      chk("t4_rw", last_rw, 0);
      // Plan 5: misaligned LW at 0x006.
      do_txn(1, 0, 2'd2, 0, 1, 5'd4, 32'h0000_0006, 32'h0, 0, 32'h0);
      settle();
      chk("t5_err", last_err, 1);
      chk("t5_rw", last_rw, 0);

      // Randomized traffic.
      for (int i = 0; i < 200; i++) begin
         int          kind, w;
         logic        rd, wr;
         logic [1:0]  sz;
         logic [31:0] a;
         kind = $urandom_range(0, 9);
         rd = (kind >= 3 && kind <= 5) || kind == 9;
         wr = (kind >= 6);
         sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = $urandom;
         if (sz != 2'd3 && $urandom_range(0, 2) != 0) a = a & ~32'(m_bytes(sz) - 1);
         w  = $urandom_range(0, 3);
         do_txn(rd, wr, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom), a, $urandom, w, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            dmem_ack = 1'($urandom_range(0, 1));
         end
      end
      repeat (4) @(negedge clk);
      #1;
      chk("drain_wbq", wbq.size(), 0);
      chk("drain_rq", rq.size(), 0);

      // Plan 6: reset during WAIT, late ack afterwards.
      chk_en = 1'b0;
      dmem_ack = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2;
      alu_result = 32'h0000_0040; reg_write = 1'b1; write_reg = 5'd2;
      @(negedge clk);
      in_valid = 1'b0;
      chk("t6_req_pre", dmem_req, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t6_req", dmem_req, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_addr", dmem_addr, 0);
      chk("t6_be", dmem_be, 0);
      chk("t6_wb_alu", wb_alu_result, 0);
      chk("t6_wb_wreg", wb_write_reg, 0);
      @(negedge clk);
      rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("t6_wb_valid", wb_valid, 0);
      chk("t6_req_post", dmem_req, 0);
      chk("t6_wb_data", wb_mem_data, 0);
      chk("t6_in_ready_post", in_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access pipeline stage sitting directly upstream of the write-back unit. It accepts one EX-stage result per transaction and issues data-memory loads and stores over a req/ack handshake with arbitrary wait states. It aligns and extends load data, and presents a registered, single-cycle-valid result bundle to write-back: mem_to_reg, write_reg, alu_result and mem_data. Misaligned or illegal accesses are suppressed and flagged.

Parameters:
XLEN, 32, datapath and address width; only 32 is supported.
REG_AW, 5, register-index width.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset; asynchronous, active-high
in_valid  in  1  upstream presents an instruction
in_ready  out  1  stage can accept; combinational, equals (state==IDLE)
mem_read  in  1  load
mem_write  in  1  store
mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
mem_unsigned  in  1  zero-extend loads when 1
reg_write  in  1  instruction writes a register
write_reg  in  REG_AW  destination register
alu_result  in  XLEN  ALU result; also the effective address for memory ops
store_data  in  XLEN  store source (low bits used)
dmem_req  out  1  memory request; registered
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  word address, {alu_result[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  XLEN  lane-replicated store data
dmem_ack  in  1  memory completes the request in this cycle
dmem_rdata  in  XLEN  read word; valid when dmem_ack=1
wb_valid  out  1  one-cycle pulse: WB bundle valid
wb_reg_write  out  1  write enable to write-back
wb_mem_to_reg  out  1  select mem_data
wb_write_reg  out  REG_AW  destination register
wb_alu_result  out  XLEN  passed-through ALU result
wb_mem_data  out  XLEN  aligned and extended load data; 0 for non-loads
misalign_err  out  1  one-cycle pulse on a rejected access

Behaviour:
- States: IDLE, WAIT. A handshake occurs when in_valid && in_ready.
- Non-memory op (mem_read=mem_write=0), accepted at edge N:
  - after edge N: wb_valid=1, wb_* loaded, wb_mem_to_reg=0, wb_mem_data=0.
  - Latency 1 cycle; stays in IDLE, so back-to-back accepts are allowed.
- Error cases: misaligned (half with addr[0]=1; word with addr[1:0]!=0), mem_size=11, or mem_read=mem_write=1.
  - No dmem_req is issued.
  - After the edge: wb_valid=1, wb_reg_write=0, misalign_err=1 for one cycle.
  - Stays in IDLE.
- Valid memory op accepted at edge N:
  - After edge N: state=WAIT; dmem_req=1; dmem_we, dmem_addr, dmem_be and dmem_wdata are registered.
  - Address lane, size and unsigned flag are captured, along with the wb fields.
  - All dmem_* outputs are held stable while dmem_req=1.
- In WAIT, on the edge where dmem_ack=1:
  - dmem_req drops and state returns to IDLE.
  - wb_valid=1 for one cycle.
  - Loads: wb_mem_to_reg=1, wb_mem_data = extracted lane, extended per mem_unsigned; wb_reg_write = captured reg_write.
  - Stores: wb_reg_write=0, wb_mem_to_reg=0, wb_mem_data=0.
- Minimum memory-op latency is 2 cycles (ack in the first request cycle). Each extra wait cycle adds one. in_ready=0 throughout WAIT.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1]? 1100 : 0011
  - word: 1111
- Store data: byte replicated ×4; half replicated ×2; word unchanged.
- dmem_ack while dmem_req=0 is ignored.
- When wb_valid=0, the other wb_* outputs hold their last values. Write-back must qualify on wb_valid.
- Reset (async, mid-transaction included):
  - state=IDLE; every output register = 0 (dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, all wb_*, misalign_err).
  - An in-flight request is abandoned; a late ack is ignored.
- in_valid is don't-care while in_ready=0; upstream must hold its instruction.

Decomposition:
- Shared package mem_stage_pkg:
  - mem_size_e (MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10)
  - mst_state_e (IDLE, WAIT)
  - XLEN and REG_AW constants
  - BE_* constants
- Sub-module load_align (combinational): inputs rdata, addr[1:0], size, unsigned; output the extended 32-bit value. Instantiated once.

Test Plan:
1. ALU op: alu_result=0x0000_1234, write_reg=5, reg_write=1 -> next cycle wb_valid=1, wb_alu_result=0x1234, wb_write_reg=5, wb_mem_to_reg=0, no dmem_req.
2. LB signed, addr 0x103, ack after 3 wait cycles, rdata 0x80FF_1122 -> dmem_addr=0x100, dmem_be=1000, dmem_req high 4 cycles, wb_mem_data=0xFFFF_FF80, wb_mem_to_reg=1, in_ready low throughout.
3. LHU addr 0x002, immediate ack, rdata 0x8001_0000 -> wb_mem_data=0x0000_8001, wb_valid two cycles after accept; next instruction accepted the following cycle.
4. SH addr 0x202, store_data 0xABCD_1234 -> dmem_we=1, dmem_be=1100, dmem_wdata=0x1234_1234; on ack wb_valid=1, wb_reg_write=0.
5. LW addr 0x006 -> misalign_err pulse, no dmem_req, wb_valid=1 with wb_reg_write=0, in_ready stays 1.
6. Assert rst during WAIT, then dmem_ack the next cycle -> dmem_req=0 immediately, state IDLE, no wb_valid, all outputs 0.
